// File: rtl/gpio_pkg.sv
// Shared types and defaults for the GPIO input filter.
// filter_cfg_t bundles the filter configuration for register-file glue.
package gpio_pkg;

   localparam int DefaultSyncStages = 2;
   localparam int DefaultNrGPIOs    = 64;
   localparam int DefaultCntWidth   = 8;
   localparam int DefaultPrescWidth = 16;

   typedef struct packed {
      logic [DefaultNrGPIOs-1:0]    bypass;
      logic [DefaultCntWidth-1:0]   threshold;
      logic [DefaultPrescWidth-1:0] prescale;
   } filter_cfg_t;

endpackage

// File: rtl/gpio_input_filter_cell.sv
// One pin: synchronizer chain, stability counter, filtered level, edge flops.
// Ports: clk_i, rst_ni, raw_i, bypass_i, tick_i, threshold_i,
//        gpio_o (filtered), rise_o/fall_o (one-cycle pulses).
// Edge flops exist only with GPIO_INPUT_FILTER_EDGE_EN defined.
module gpio_input_filter_cell
   import gpio_pkg::*;
#(
   parameter int SyncStages = DefaultSyncStages,
   parameter int CntWidth   = DefaultCntWidth
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                raw_i,
   input  logic                bypass_i,
   input  logic                tick_i,
   input  logic [CntWidth-1:0] threshold_i,
   output logic                gpio_o,
   output logic                rise_o,
   output logic                fall_o
);

   logic [SyncStages-1:0] sync_q;
   logic                  sync;
   logic [CntWidth-1:0]   cnt_q, cnt_d;
   logic                  gpio_q, gpio_d;

   assign sync = sync_q[SyncStages-1];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
         cnt_q  <= '0;
         gpio_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SyncStages-2:0], raw_i};
         cnt_q  <= cnt_d;
         gpio_q <= gpio_d;
      end
   end

   // Any tick with agreement restarts the count, so glitches shorter
   // than T+1 ticks never reach the output.
   always_comb begin
      gpio_d = gpio_q;
      cnt_d  = cnt_q;
      if (bypass_i) begin
         gpio_d = sync;
         cnt_d  = '0;
      end else if (sync == gpio_q) begin
         cnt_d  = '0;
      end else if (tick_i) begin
         // >= lets a lowered threshold take effect on the next tick
         if (cnt_q >= threshold_i) begin
            gpio_d = sync;
            cnt_d  = '0;
         end else begin
            cnt_d  = cnt_q + 1'b1;
         end
      end
   end

   assign gpio_o = gpio_q;

`ifdef GPIO_INPUT_FILTER_EDGE_EN
   logic rise_q, fall_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= ~gpio_q & gpio_d;
         fall_q <= gpio_q & ~gpio_d;
      end
   end

   assign rise_o = rise_q;
   assign fall_o = fall_q;
`else
   assign rise_o = 1'b0;
   assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/gpio_input_filter.sv
// Per-pin synchronizer + debounce filter in front of the GPIO peripheral.
// Ports: clk_i, rst_ni, gpio_raw_i, cfg_bypass_i, cfg_threshold_i (T),
//        cfg_prescale_i (P), gpio_o, rise_o, fall_o.
// Macro GPIO_INPUT_FILTER_EDGE_EN enables the rise/fall pulse registers.
module gpio_input_filter
   import gpio_pkg::*;
#(
   parameter int NrGPIOs    = DefaultNrGPIOs,
   parameter int SyncStages = DefaultSyncStages,
   parameter int CntWidth   = DefaultCntWidth,
   parameter int PrescWidth = DefaultPrescWidth
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [NrGPIOs-1:0]    gpio_raw_i,
   input  logic [NrGPIOs-1:0]    cfg_bypass_i,
   input  logic [CntWidth-1:0]   cfg_threshold_i,
   input  logic [PrescWidth-1:0] cfg_prescale_i,
   output logic [NrGPIOs-1:0]    gpio_o,
   output logic [NrGPIOs-1:0]    rise_o,
   output logic [NrGPIOs-1:0]    fall_o
);

   logic [PrescWidth-1:0] presc_q;
   logic                  tick;

   // >= so a prescale shrunk below the current count ticks at once
   assign tick = (presc_q >= cfg_prescale_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         presc_q <= '0;
      end else if (tick) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_q + 1'b1;
      end
   end

   for (genvar i = 0; i < NrGPIOs; i++) begin : g_pin
      gpio_input_filter_cell #(
         .SyncStages (SyncStages),
         .CntWidth   (CntWidth)
      ) u_cell (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .raw_i       (gpio_raw_i[i]),
         .bypass_i    (cfg_bypass_i[i]),
         .tick_i      (tick),
         .threshold_i (cfg_threshold_i),
         .gpio_o      (gpio_o[i]),
         .rise_o      (rise_o[i]),
         .fall_o      (fall_o[i])
      );
   end

endmodule

// File: tb/tb_gpio_input_filter.sv
// Directed bench for gpio_input_filter with hand-computed timings.
// Edge expectations follow GPIO_INPUT_FILTER_EDGE_EN.
module tb_gpio_input_filter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] raw, byp, gpio, rise, fall;
   logic [7:0]  thr;
   logic [15:0] presc;
   int          n_pass = 0;
   int          n_chk = 0;

   always #5 clk = ~clk;

   gpio_input_filter dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .gpio_raw_i      (raw),
      .cfg_bypass_i    (byp),
      .cfg_threshold_i (thr),
      .cfg_prescale_i  (presc),
      .gpio_o          (gpio),
      .rise_o          (rise),
      .fall_o          (fall)
   );

`ifdef GPIO_INPUT_FILTER_EDGE_EN
   localparam bit EdgeEn = 1'b1;
`else
   localparam bit EdgeEn = 1'b0;
`endif

   function automatic logic [63:0] e(input logic [63:0] v);
      return EdgeEn ? v : 64'h0;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, got, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // cycles until gpio[pin] differs from old, 99 on timeout
   task automatic wait_chg(input int pin, input logic old,
                           input int lim, output int n);
      n = 99;
      for (int k = 1; k <= lim; k++) begin
         step(1);
         if (gpio[pin] !== old) begin
            n = k;
            break;
         end
      end
   endtask

   logic [63:0] seen;
   int          n;

   initial begin
      rst_n = 1'b0;
      raw   = '1;
      byp   = '0;
      thr   = 8'd3;
      presc = 16'd0;
      step(3);
      chk("rst_gpio", gpio, 64'h0);
      chk("rst_rise", rise, 64'h0);
      chk("rst_fall", fall, 64'h0);

      // release with raw all ones
      rst_n = 1'b1;
      seen  = '0;
      for (int k = 0; k < 5; k++) begin
         step(1);
         seen |= rise | fall | gpio;
      end
      chk("rel_hold5", seen, 64'h0);
      step(1);
      chk("rel_gpio6", gpio, '1);
      chk("rel_rise6", rise, e('1));
      step(1);
      chk("rel_rise1", rise, 64'h0);

      // drop all, fall after 6
      raw = '0;
      step(5);
      chk("drop_hold", gpio, '1);
      step(1);
      chk("drop_gpio", gpio, 64'h0);
      chk("drop_fall", fall, e('1));
      step(2);

      // 3-cycle glitch on pin 0 is filtered
      raw[0] = 1'b1;
      seen = '0;
      for (int k = 0; k < 12; k++) begin
         step(1);
         if (k == 2) raw[0] = 1'b0;
         seen |= rise | gpio;
      end
      chk("glitch", seen, 64'h0);

      // held pulse on pin 0
      raw[0] = 1'b1;
      step(5);
      chk("pin0_hold", gpio, 64'h0);
      step(1);
      chk("pin0_gpio", gpio, 64'h1);
      chk("pin0_rise", rise, e(64'h1));
      step(1);

      // T=1 P=4 latency window on pin 1
      thr   = 8'd1;
      presc = 16'd4;
      step(3);
      raw[1] = 1'b1;
      wait_chg(1, 1'b0, 30, n);
      chk("presc_win", 64'(n >= 8 && n <= 12), 64'h1);
      chk("presc_gpio", gpio, 64'h3);

      // large P stalls; shrinking it ticks at once
      presc  = 16'd1000;
      raw[1] = 1'b0;
      step(50);
      chk("stall", gpio, 64'h3);
      presc = 16'd4;
      wait_chg(1, 1'b1, 30, n);
      chk("shrink_lat", 64'(n), 64'd6);
      chk("shrink_fall", fall, e(64'h2));

      // bypass pin 5 with huge T; pin 6 filtered
      rst_n = 1'b0;
      #1;
      chk("mid_rst", gpio, 64'h0);
      raw   = '0;
      byp   = 64'h20;
      thr   = 8'd255;
      presc = 16'd0;
      step(2);
      rst_n = 1'b1;
      step(4);
      chk("norel_pulse", rise | fall | gpio, 64'h0);
      raw = 64'h60;
      step(2);
      chk("byp_hold", gpio, 64'h0);
      step(1);
      chk("byp_gpio", gpio, 64'h20);
      chk("byp_rise", rise, e(64'h20));
      step(7);
      chk("filt_hold", gpio, 64'h20);
      // lowering T mid-count updates on next tick
      thr = 8'd3;
      step(1);
      chk("thr_low", gpio, 64'h60);
      chk("thr_rise", rise, e(64'h40));

      // opposite toggles on pins 0 and 63
      byp = '0;
      thr = 8'd0;
      raw = 64'h8000_0000_0000_0000;
      step(3);
      chk("p63_up", gpio, 64'h8000_0000_0000_0000);
      raw = 64'h1;
      step(2);
      chk("opp_hold", gpio, 64'h8000_0000_0000_0000);
      step(1);
      chk("opp_gpio", gpio, 64'h1);
      chk("opp_rise", rise, e(64'h1));
      chk("opp_fall", fall, e(64'h8000_0000_0000_0000));
      step(1);
      chk("opp_clr", rise | fall, 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/gpio_input_filter.md
Name: gpio_input_filter

Overview:
- Per-pin synchronizer and debounce filter that sits directly upstream of the GPIO peripheral.
- Takes raw pad inputs; its filtered output drives the peripheral's `gpio_in` port.
- Removes metastability and glitches shorter than a programmable stable time.
- Emits single-cycle rise/fall pulses that interrupt or event logic can consume.

Parameters:
- NrGPIOs, 64: number of pins; must match the downstream GPIO peripheral.
- SyncStages, 2: flip-flop stages in each input synchronizer; minimum 2.
- CntWidth, 8: width of the per-pin stability counter and of the threshold.
- PrescWidth, 16: width of the shared tick prescaler.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous active-low.
- gpio_raw_i  in  NrGPIOs  raw pad inputs, asynchronous to clk_i.
- cfg_bypass_i  in  NrGPIOs  per pin: 1 = synchronize only, no debounce.
- cfg_threshold_i  in  CntWidth  stable ticks required minus one (T).
- cfg_prescale_i  in  PrescWidth  tick period minus one (P).
- gpio_o  out  NrGPIOs  filtered level; connects to the GPIO peripheral's `gpio_in`.
- rise_o  out  NrGPIOs  one-cycle pulse when gpio_o goes 0->1.
- fall_o  out  NrGPIOs  one-cycle pulse when gpio_o goes 1->0.

Behaviour:
- Reset: all synchronizer flops, gpio_o, rise_o, fall_o, stability counters and the prescaler counter are 0.
- Synchronizer: SyncStages-flop chain per pin. `sync[i]` is the last stage.
- Prescaler:
  - presc_cnt increments every cycle.
  - When presc_cnt >= cfg_prescale_i, tick=1 for that cycle and presc_cnt<=0.
  - The `>=` compare prevents lockup when cfg_prescale_i shrinks at run time.
  - P=0 gives tick every cycle.
- Per pin, debounce mode (cfg_bypass_i[i]=0):
  - If sync[i]==gpio_o[i]: cnt[i]<=0 every cycle, regardless of tick. This is the glitch restart.
  - If sync[i]!=gpio_o[i] and tick and cnt[i]>=T: gpio_o[i]<=sync[i], cnt[i]<=0.
  - If sync[i]!=gpio_o[i] and tick and cnt[i]<T: cnt[i]<=cnt[i]+1. The counter never wraps; it is bounded by T.
  - If sync[i]!=gpio_o[i] and no tick: cnt[i] holds.
  - gpio_o therefore updates on the (T+1)-th consecutive mismatch tick.
- Latency:
  - P=0: raw edge to gpio_o edge = SyncStages+T+1 cycles.
  - P>0: between SyncStages+T*(P+1)+1 and SyncStages+(T+1)*(P+1) cycles, depending on prescaler phase.
- Bypass (cfg_bypass_i[i]=1): gpio_o[i]<=sync[i] every cycle, cnt[i]<=0. Latency SyncStages+1.
- Bypass toggled mid-count: the counter restarts from 0 and no spurious update occurs.
- cfg_threshold_i lowered mid-count: because the compare is `>=`, the pin updates on the next mismatch tick.
- Edge pulses:
  - rise_o[i]<=~gpio_o[i] & next_gpio_o[i]; fall_o[i]<=gpio_o[i] & ~next_gpio_o[i].
  - Both are registered, so they assert in the same cycle gpio_o changes, for exactly one cycle.
  - They are never both high.
- Pins are fully independent; simultaneous changes on several pins are all handled in the same cycle.
- Reset asserted mid-operation returns everything to reset values immediately. No pulses are produced on reset release, even if the raw input is 1; the 0->1 update then goes through the normal filter.

Optional Feature:
- Macro: GPIO_INPUT_FILTER_EDGE_EN.
- Defined: rise_o/fall_o behave as above.
- Undefined: the edge registers are not instantiated and rise_o/fall_o are tied to constant 0. Ports remain present, so instantiations are unchanged.

Decomposition:
- gpio_pkg holds:
  - filter_cfg_t, a packed struct {bypass, threshold, prescale} for use by register-file glue;
  - localparam DefaultSyncStages=2.
- Natural sub-module gpio_input_filter_cell: one pin's synchronizer, counter and edge flops. It takes the shared tick, threshold and bypass as inputs and is instantiated NrGPIOs times in a generate loop.
- The prescaler stays in the top module.

Test Plan:
- Reset release with gpio_raw_i=all 1s, T=3, P=0 -> gpio_o stays 0 for 5 cycles, rises in cycle 6, rise_o=1 for that one cycle only.
- T=3, P=0, pin 0 pulses high for 3 cycles (glitch) -> gpio_o[0] stays 0, no rise_o. Pulse held for 4+ cycles -> gpio_o[0] rises 6 cycles after the raw edge.
- T=1, P=4, steady raw change -> gpio_o changes between 8 and 12 cycles after the raw edge. Reprogramming P from 1000 to 4 mid-count -> next tick within 1 cycle, no lockup.
- cfg_bypass_i[5]=1, T=255 -> pin 5 follows raw with 3-cycle latency. Other pins are still filtered.
- Pins 0 and 63 toggle opposite directions in the same cycle -> rise_o[0] and fall_o[63] assert in the same cycle.
- Build without GPIO_INPUT_FILTER_EDGE_EN -> rise_o/fall_o constant 0 through all of the above, while gpio_o timing is identical.
